cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each result producer feeds a small FIFO. A
// round-robin arbiter pops one head per cycle into the registered
// broadcast (cdb_*) outputs.

`ifndef Reg_Lock_Width
`define Reg_Lock_Width 6
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock {`Reg_Lock_Width{1'b0}}
`endif

module cdb_arbiter #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [NUM_SRC-1:0]                    src_valid,
    input  logic [NUM_SRC*`Reg_Lock_Width-1:0]    src_index,
    input  logic [NUM_SRC*`Data_Width-1:0]        src_result,
    output logic [NUM_SRC-1:0]                    src_stall,
    output logic                                  cdb_valid,
    output logic [`Reg_Lock_Width-1:0]            cdb_index,
    output logic [`Data_Width-1:0]                cdb_result
);

    localparam int unsigned LockW = `Reg_Lock_Width;
    localparam int unsigned DataW = `Data_Width;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned SrcW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Entry storage is never reset; occupancy is tracked by the counters alone.
    logic [LockW-1:0] idx_mem  [NUM_SRC][FIFO_DEPTH];
    logic [DataW-1:0] data_mem [NUM_SRC][FIFO_DEPTH];

    logic [CntW-1:0]  cnt_q    [NUM_SRC];
    logic [PtrW-1:0]  rd_ptr_q [NUM_SRC];
    logic [PtrW-1:0]  wr_ptr_q [NUM_SRC];
    logic [SrcW-1:0]  last_grant_q;

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_valid;
    logic [SrcW-1:0]    grant_src;
    int                 cand;

    // Stall from registered occupancy only; push qualification per source.
    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_stall[i] = (cnt_q[i] == CntW'(FIFO_DEPTH));
            push[i]      = src_valid[i] && !src_stall[i] && !flush &&
                           (src_index[i*LockW +: LockW] != `Reg_No_Lock);
        end
    end

    // Round-robin search starting one past the last granted source.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = '0;
        cand        = 0;
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            cand = (int'(last_grant_q) + k) % int'(NUM_SRC);
            if (!grant_valid && (cnt_q[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_src   = SrcW'(cand);
            end
        end
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            pop[i] = grant_valid && !flush && (grant_src == SrcW'(i));
        end
    end

    // FIFO pointers and occupancy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
                if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + CntW'(1);
                else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - CntW'(1);
            end
        end
    end

    // Entry storage writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (push[i]) begin
                idx_mem[i][wr_ptr_q[i]]  <= src_index[i*LockW +: LockW];
                data_mem[i][wr_ptr_q[i]] <= src_result[i*DataW +: DataW];
            end
        end
    end

    // Broadcast registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid    <= 1'b0;
            cdb_index    <= `Reg_No_Lock;
            cdb_result   <= '0;
            last_grant_q <= SrcW'(NUM_SRC - 1);
        end else if (flush || !grant_valid) begin
            cdb_valid  <= 1'b0;
            cdb_index  <= `Reg_No_Lock;
            cdb_result <= '0;
        end else begin
            cdb_valid    <= 1'b1;
            cdb_index    <= idx_mem[grant_src][rd_ptr_q[grant_src]];
            cdb_result   <= data_mem[grant_src][rd_ptr_q[grant_src]];
            last_grant_q <= grant_src;
        end
    end

endmodule
